snake_dir_ctrl: RTL and testbench
=================================

Name: snake_dir_ctrl

Overview:
- Upstream control stage for the VGA snake path.
- Turns the four raw board buttons into a registered, reversal-safe direction, and generates the game-step tick.
- Keeps the snake head position on a cell grid, with wrap-around at the edges.
- Its outputs feed the VGA drawing stage, replacing both the button-edge latch and the separate prescaled clock.

Parameters:
- DEBOUNCE_CYC, 250000: number of consecutive stable cycles needed to accept a button level (about 10 ms at 25.175 MHz).
- TICK_CYC, 6293750: iCLK cycles per game step (about 4 Hz).
- GRID_W, 64: grid columns (640 / 10-pixel cells).
- GRID_H, 48: grid rows (480 / 10).
- HEAD_X0, 32: head column at reset.
- HEAD_Y0, 24: head row at reset.

Ports:
- iCLK  in  1  pixel clock; the single clock domain.
- iRST  in  1  asynchronous, active-high reset.
- iUpButton  in  1  raw button, active-high, asynchronous to iCLK.
- iDownButton  in  1  raw button, active-high.
- iLeftButton  in  1  raw button, active-high.
- iRightButton  in  1  raw button, active-high.
- oDirection  out  2  committed direction: 11 = up, 00 = down, 10 = left, 01 = right.
- oTick  out  1  one-cycle step pulse.
- oHead_X  out  $clog2(GRID_W)  head column.
- oHead_Y  out  $clog2(GRID_H)  head row.

Behaviour:
- Reset: one clock, iCLK; iRST is asynchronous and active-high. While iRST is high:
  - oDirection = 01, pending direction = 01, oTick = 0.
  - oHead_X = HEAD_X0, oHead_Y = HEAD_Y0.
  - All counters = 0; debounced levels and synchronizers = 0.
  - Reset asserted mid-operation takes effect immediately; any pending press is discarded.
- Per-button input path:
  - 2-flop synchronizer.
  - Debounce counter: clears whenever the synchronized level differs from the debounced level; when the count reaches DEBOUNCE_CYC-1, the debounced level takes the synchronized value.
  - Press event = rising edge of the debounced level, exactly 1 cycle wide.
  - Press-to-event latency: 2 sync cycles + DEBOUNCE_CYC cycles + 1 cycle.
- Press arbitration:
  - Simultaneous press events in one cycle: priority up > down > left > right; only the winner is considered.
  - A press is accepted into the pending register only if it is not the opposite of the committed oDirection. Opposite is defined as new == ~oDirection (bitwise).
  - A rejected press leaves pending unchanged.
  - A press equal to oDirection rewrites pending with the same value (no-op).
  - Several accepted presses between ticks: the last one wins.
  - The reversal check is always made against committed oDirection, never against pending.
- Tick counter:
  - Counts 0..TICK_CYC-1, then wraps to 0.
  - At the wrap edge, registered outputs update together:
    - oTick = 1 for one cycle.
    - oDirection <= pending.
    - Head steps one cell in the new direction: up = Y-1, down = Y+1, left = X-1, right = X+1.
  - New head coordinates and direction are valid in the same cycle oTick is high; they are stable until the next tick.
- Wrap-around:
  - X = GRID_W-1 moving right -> 0; X = 0 moving left -> GRID_W-1.
  - Y = 0 moving up -> GRID_H-1; Y = GRID_H-1 moving down -> 0.
  - All grid arithmetic is compared explicitly, with no reliance on modulo-2^n overflow (GRID_H is not a power of two).
- A press event in the same cycle as a tick is evaluated after the commit: it is checked against the new oDirection and applies to the following tick.

Optional Feature:
- Macro: SNAKE_PAUSE_EN.
- Defined:
  - Adds port iPauseButton (in, 1), using the same sync/debounce path.
  - Each press event toggles an internal paused flag; reset clears it.
  - While paused: the tick counter holds its value, oTick stays 0, head and direction hold, and direction presses are ignored.
- Undefined: no port, no flag; behaviour is exactly as above.

Decomposition:
- snake_pkg:
  - DIR_UP = 2'b11, DIR_DOWN = 2'b00, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b01.
  - Default GRID_W and GRID_H.
  - Function is_opposite(a, b).
- Sub-module btn_debounce (parameter DEBOUNCE_CYC; ports iCLK, iRST, iRaw, oLevel, oPress): synchronizer, counter and edge detect. Instantiated 4 times, or 5 with SNAKE_PAUSE_EN.

Test Plan (simulation uses DEBOUNCE_CYC = 8, TICK_CYC = 4):
- Reset released, no buttons pressed -> oTick every 4 cycles; head steps (32,24) -> (33,24) -> (34,24); oDirection = 01.
- iUpButton toggled every 3 cycles for 30 cycles -> no press event, direction stays 01. Then held high for 12 cycles -> on the next tick oDirection = 11 and Y = 23.
- Moving right, iLeftButton held -> press rejected, X keeps incrementing. Then up is accepted, and a left press before the next tick is still rejected (committed direction is still right).
- Head at (63,10) moving right -> next tick gives (0,10). Head at (5,0) moving up -> next tick gives (5,47).
- Up and left debounced in the same cycle while moving right -> oDirection = 11 after the next tick.
- iRST pulsed for 1 cycle between ticks with a press pending -> outputs return to reset values without waiting for a clock edge; the first tick comes 4 cycles after release, moving right.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snake_pkg
// Purpose : Shared direction codes, grid defaults and helpers for the snake
//           control path.
// Rev     : 1.0  initial release
// ============================================================================
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b11;
  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  localparam int c_GRID_W_DEFAULT = 64;
  localparam int c_GRID_H_DEFAULT = 48;

  // The encoding is chosen so that opposite directions are bitwise complements.
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a == ~b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : Two-flop synchronizer, stable-level debounce and rising-edge
//           press pulse for one raw board button.
// Rev     : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iRaw,
  output logic oLevel,
  output logic oPress
);

  localparam int c_CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [1:0]         r_sync;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_levelQ;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sync   <= 2'b00;
      r_cnt    <= '0;
      oLevel   <= 1'b0;
      r_levelQ <= 1'b0;
      oPress   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], iRaw};
      // The count only runs while the synchronized level disagrees with the accepted one.
      if (r_sync[1] == oLevel) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        oLevel <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      r_levelQ <= oLevel;
      oPress   <= oLevel & ~r_levelQ;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : snake_dir_ctrl
// Purpose : Debounced, reversal-safe snake direction, game-step tick and
//           wrapping head position. Optional pause button: SNAKE_PAUSE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int TICK_CYC     = 6293750,
  parameter int GRID_W       = c_GRID_W_DEFAULT,
  parameter int GRID_H       = c_GRID_H_DEFAULT,
  parameter int HEAD_X0      = 32,
  parameter int HEAD_Y0      = 24
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iUpButton,
  input  logic                      iDownButton,
  input  logic                      iLeftButton,
  input  logic                      iRightButton,
`ifdef SNAKE_PAUSE_EN
  input  logic                      iPauseButton,
`endif
  output logic [1:0]                oDirection,
  output logic                      oTick,
  output logic [$clog2(GRID_W)-1:0] oHead_X,
  output logic [$clog2(GRID_H)-1:0] oHead_Y
);

  localparam int c_XW     = $clog2(GRID_W);
  localparam int c_YW     = $clog2(GRID_H);
  localparam int c_TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  localparam logic [c_XW-1:0]     c_X_MAX     = c_XW'(GRID_W - 1);
  localparam logic [c_YW-1:0]     c_Y_MAX     = c_YW'(GRID_H - 1);
  localparam logic [c_XW-1:0]     c_X_ONE     = c_XW'(1);
  localparam logic [c_YW-1:0]     c_Y_ONE     = c_YW'(1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYC - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);

  logic [3:0]          w_raw;
  logic [3:0]          w_level;
  logic [3:0]          w_pulse;
  logic [3:0]          w_press;
  logic                w_run;
  logic                w_tickNow;
  logic                w_pressValid;
  logic [1:0]          w_pressDir;
  logic [1:0]          w_commitDir;
  logic [c_XW-1:0]     w_nextX;
  logic [c_YW-1:0]     w_nextY;
  logic [1:0]          r_pending;
  logic [c_TICK_W-1:0] r_tickCnt;

  assign w_raw = {iUpButton, iDownButton, iLeftButton, iRightButton};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iRaw  (w_raw[i]),
        .oLevel(w_level[i]),
        .oPress(w_pulse[i])
      );
    end
  endgenerate

  assign w_press = w_pulse & w_level;

`ifdef SNAKE_PAUSE_EN
  logic r_paused;
  logic w_pauseLevel;
  logic w_pausePulse;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iRaw  (iPauseButton),
    .oLevel(w_pauseLevel),
    .oPress(w_pausePulse)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_paused <= 1'b0;
    end else if (w_pausePulse & w_pauseLevel) begin
      r_paused <= ~r_paused;
    end
  end

  assign w_run = ~r_paused;
`else
  assign w_run = 1'b1;
`endif

  assign w_tickNow = w_run && (r_tickCnt == c_TICK_LAST);
  // A press landing on a tick is judged against the direction being committed now.
  assign w_commitDir = w_tickNow ? r_pending : oDirection;

  always_comb begin
    w_pressValid = w_run;
    w_pressDir   = DIR_RIGHT;
    if (w_press[3])      w_pressDir = DIR_UP;
    else if (w_press[2]) w_pressDir = DIR_DOWN;
    else if (w_press[1]) w_pressDir = DIR_LEFT;
    else if (w_press[0]) w_pressDir = DIR_RIGHT;
    else                 w_pressValid = 1'b0;
  end

  always_comb begin
    w_nextX = oHead_X;
    w_nextY = oHead_Y;
    case (r_pending)
      DIR_UP:   w_nextY = (oHead_Y == '0)      ? c_Y_MAX : oHead_Y - c_Y_ONE;
      DIR_DOWN: w_nextY = (oHead_Y == c_Y_MAX) ? '0      : oHead_Y + c_Y_ONE;
      DIR_LEFT: w_nextX = (oHead_X == '0)      ? c_X_MAX : oHead_X - c_X_ONE;
      default:  w_nextX = (oHead_X == c_X_MAX) ? '0      : oHead_X + c_X_ONE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDirection <= DIR_RIGHT;
      r_pending  <= DIR_RIGHT;
      oTick      <= 1'b0;
      r_tickCnt  <= '0;
      oHead_X    <= c_XW'(HEAD_X0);
      oHead_Y    <= c_YW'(HEAD_Y0);
    end else begin
      oTick <= w_tickNow;
      if (w_run) begin
        r_tickCnt <= w_tickNow ? '0 : r_tickCnt + c_TICK_ONE;
      end
      if (w_tickNow) begin
        oDirection <= r_pending;
        oHead_X    <= w_nextX;
        oHead_Y    <= w_nextY;
      end
      if (w_pressValid && !is_opposite(w_pressDir, w_commitDir)) begin
        r_pending <= w_pressDir;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_snake_dir_ctrl
// Purpose : Directed self-checking bench for snake_dir_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_snake_dir_ctrl;

  localparam int DEB  = 8;
  localparam int TICK = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       up    = 1'b0;
  logic       down  = 1'b0;
  logic       left  = 1'b0;
  logic       right = 1'b0;
`ifdef SNAKE_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [1:0] dir;
  logic       tick;
  logic [5:0] headX;
  logic [5:0] headY;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  snake_dir_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .TICK_CYC    (TICK),
    .GRID_W      (64),
    .GRID_H      (48),
    .HEAD_X0     (32),
    .HEAD_Y0     (24)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iUpButton   (up),
    .iDownButton (down),
    .iLeftButton (left),
    .iRightButton(right),
`ifdef SNAKE_PAUSE_EN
    .iPauseButton(pause),
`endif
    .oDirection  (dir),
    .oTick       (tick),
    .oHead_X     (headX),
    .oHead_Y     (headY)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkHead(input string tag, input int x, input int y, input int d);
    checkVal({tag, "_x"},   32'(headX), 32'(x));
    checkVal({tag, "_y"},   32'(headY), 32'(y));
    checkVal({tag, "_dir"}, 32'(dir),   32'(d));
  endtask

  // Returns on the falling edge where oTick is seen high; n counts cycles waited.
  task automatic waitTick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 20);
    if (tick !== 1'b1) checkVal("tick_timeout", 32'(0), 32'(1));
  endtask

  task automatic ticks(input int k);
    int n;
    repeat (k) waitTick(n);
  endtask

  // mask = {up, down, left, right}
  task automatic hold(input logic [3:0] mask, input int cyc);
    {up, down, left, right} = mask;
    repeat (cyc) @(negedge clk);
    {up, down, left, right} = 4'b0000;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    checkHead("reset", 32, 24, 1);
    checkVal("reset_tick", 32'(tick), 32'(0));
    rst = 1'b0;

    waitTick(n);
    checkVal("first_tick_gap", 32'(n), 32'(4));
    checkHead("step1", 33, 24, 1);
    @(negedge clk);
    checkVal("tick_width", 32'(tick), 32'(0));
    waitTick(n);
    checkVal("tick_period", 32'(n), 32'(3));
    checkHead("step2", 34, 24, 1);

    // Bouncing up button: never stable for 8 cycles, 7 ticks elapse.
    for (int i = 0; i < 5; i++) begin
      up = 1'b1; repeat (3) @(negedge clk);
      up = 1'b0; repeat (3) @(negedge clk);
    end
    checkHead("bounce", 41, 24, 1);

    hold(4'b1000, 12);
    waitTick(n);
    checkHead("up_accept", 44, 23, 3);

    // Right press lands exactly on a tick edge.
    hold(4'b0001, 12);
    waitTick(n);
    checkHead("right_at_tick", 45, 20, 1);

    hold(4'b0010, 12);
    waitTick(n);
    checkHead("left_reject", 49, 20, 1);
    ticks(2);
    checkHead("settle", 51, 20, 1);

    // Up is accepted, then left one cycle later is judged against committed right.
    @(negedge clk);
    up = 1'b1;
    @(negedge clk);
    left = 1'b1;
    repeat (12) @(negedge clk);
    up = 1'b0; left = 1'b0;
    waitTick(n);
    checkHead("vs_committed", 54, 19, 3);

    ticks(6);
    checkHead("pre_turn", 54, 13, 3);
    hold(4'b0001, 12);
    waitTick(n);
    checkHead("turn_right", 55, 10, 1);
    ticks(8);
    checkHead("x_edge", 63, 10, 1);
    waitTick(n);
    checkHead("wrap_right", 0, 10, 1);

    ticks(2);
    repeat (2) @(negedge clk);
    hold(4'b1000, 12);
    waitTick(n);
    checkHead("turn_up", 5, 9, 3);
    ticks(9);
    checkHead("y_edge", 5, 0, 3);
    waitTick(n);
    checkHead("wrap_up", 5, 47, 3);

    hold(4'b0001, 12);
    waitTick(n);
    checkHead("back_right", 6, 44, 1);
    hold(4'b1010, 12);
    waitTick(n);
    checkHead("priority", 9, 43, 3);

    // Leave a left press pending, then pulse reset between ticks.
    ticks(3);
    checkHead("pre_reset", 9, 40, 3);
    @(negedge clk);
    hold(4'b0010, 12);
    #2 rst = 1'b1;
    #1;
    checkHead("async_reset", 32, 24, 1);
    checkVal("async_reset_tick", 32'(tick), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    waitTick(n);
    checkVal("post_reset_gap", 32'(n), 32'(4));
    checkHead("post_reset", 33, 24, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire
